sram_like_arbiter: RTL and testbench

Shares one sram-like memory port between the fetch side (instruction reads) and the memory stage (data reads/writes) of the 5-stage MIPS core. It sits between the fetch/MEM stages and the external sram-like slave, granting one transaction at a time. Data requests have fixed priority over instruction requests. A pipeline flush cancels delivery of an in-flight instruction response.

---
 rtl/sram_like_arbiter_pkg.sv | 20 ++
 rtl/sram_like_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the fetch/MEM sram-like port arbiter.
// States, owner codes and access-size codes.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between fetch and MEM stage.
// Data has fixed priority; a flush drops an in-flight fetch response.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t state, state_nx;
  arb_owner_t owner, owner_nx;
  logic       cancel, cancel_nx;
  arb_owner_t sel;
  logic       granted;
  logic       rsp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ARB_IDLE;
      owner  <= OWN_INST;
      cancel <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      cancel <= cancel_nx;
    end
  end

  always_comb begin
    granted   = 1'b0;
    sel       = owner;
    state_nx  = state;
    owner_nx  = owner;
    cancel_nx = cancel;
    rsp       = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        granted  = data_req | inst_req;
        sel      = data_req ? OWN_DATA : OWN_INST;
        if (granted) begin
          owner_nx = sel;
          state_nx = mem_addr_ok ? ARB_WAIT : ARB_REQ;
          // a flush racing the fetch accept must still drop its response
          if (mem_addr_ok && flush && sel == OWN_INST)
            cancel_nx = 1'b1;
        end
      end
      ARB_REQ: begin
        granted = 1'b1;
        if (mem_addr_ok)
          state_nx = ARB_WAIT;
        if (flush && owner == OWN_INST)
          cancel_nx = 1'b1;
      end
      ARB_WAIT: begin
        rsp = mem_data_ok;
        if (flush && owner == OWN_INST)
          cancel_nx = 1'b1;
        if (mem_data_ok) begin
          state_nx  = ARB_IDLE;
          cancel_nx = 1'b0;
        end
      end
      default: begin
        state_nx  = ARB_IDLE;
        cancel_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_req   = granted;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (granted) begin
      if (sel == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = SZ_WORD;
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = granted & (sel == OWN_INST) & mem_addr_ok;
  assign data_addr_ok = granted & (sel == OWN_DATA) & mem_addr_ok;

  assign inst_data_ok = rsp & (owner == OWN_INST) & ~cancel & ~flush;
  assign data_data_ok = rsp & (owner == OWN_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: grant order, hold-off,
// flush cancellation and mid-transaction reset.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    flush       = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    quiet();
    inst_addr  = '0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
    tick();
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ok", 32'({inst_addr_ok, inst_data_ok,
                       data_addr_ok, data_data_ok}), 32'd0);
    resetn = 1'b1;
    tick();

    // inst-only read
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc00000;
    mem_addr_ok = 1'b1;
    settle();
    chk("i_mem_req", 32'(mem_req), 32'd1);
    chk("i_mem_addr", mem_addr, 32'hbfc00000);
    chk("i_mem_wr", 32'(mem_wr), 32'd0);
    chk("i_mem_size", 32'(mem_size), 32'd2);
    chk("i_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("i_d_addr_ok", 32'(data_addr_ok), 32'd0);
    tick();
    quiet();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3c1d0000;
    settle();
    chk("i_wait_req", 32'(mem_req), 32'd0);
    chk("i_data_ok", 32'(inst_data_ok), 32'd1);
    chk("i_rdata", inst_rdata, 32'h3c1d0000);
    chk("i_d_data_ok", 32'(data_data_ok), 32'd0);
    tick();
    quiet();

    // simultaneous data write and inst read
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_size   = 2'd0;
    data_addr   = 32'h00001000;
    data_wdata  = 32'hdeadbeef;
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc00004;
    mem_addr_ok = 1'b1;
    settle();
    chk("p_mem_addr", mem_addr, 32'h00001000);
    chk("p_wdata", mem_wdata, 32'hdeadbeef);
    chk("p_size", 32'(mem_size), 32'd0);
    chk("p_wr", 32'(mem_wr), 32'd1);
    chk("p_d_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("p_i_addr_ok", 32'(inst_addr_ok), 32'd0);
    tick();
    data_req = 1'b0;
    settle();
    chk("p_wait_req", 32'(mem_req), 32'd0);
    chk("p_wait_iaok", 32'(inst_addr_ok), 32'd0);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    chk("p_d_data_ok", 32'(data_data_ok), 32'd1);
    chk("p_i_data_ok", 32'(inst_data_ok), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("p_i_mem_addr", mem_addr, 32'hbfc00004);
    chk("p_i_addr_ok2", 32'(inst_addr_ok), 32'd1);
    tick();
    quiet();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h24080001;
    settle();
    chk("p_i_data_ok2", 32'(inst_data_ok), 32'd1);
    chk("p_i_rdata2", inst_rdata, 32'h24080001);
    tick();
    quiet();

    // slave stalls the inst address; data must not preempt
    inst_req  = 1'b1;
    inst_addr = 32'hbfc00008;
    settle();
    chk("h_idle_addr", mem_addr, 32'hbfc00008);
    chk("h_idle_aok", 32'(inst_addr_ok), 32'd0);
    tick();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h00002000;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("h_req_addr", mem_addr, 32'hbfc00008);
      chk("h_req_wr", 32'(mem_wr), 32'd0);
      chk("h_req_daok", 32'(data_addr_ok), 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("h_accept_addr", mem_addr, 32'hbfc00008);
    chk("h_accept_iaok", 32'(inst_addr_ok), 32'd1);
    chk("h_accept_daok", 32'(data_addr_ok), 32'd0);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h11111111;
    settle();
    chk("h_i_data_ok", 32'(inst_data_ok), 32'd1);
    chk("h_d_data_ok", 32'(data_data_ok), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("h_d_addr", mem_addr, 32'h00002000);
    chk("h_d_aok", 32'(data_addr_ok), 32'd1);
    tick();

    // flush during a data read wait does not drop it
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    flush       = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h22222222;
    settle();
    chk("fd_data_ok", 32'(data_data_ok), 32'd1);
    chk("fd_rdata", data_rdata, 32'h22222222);
    tick();
    quiet();

    // flush during inst wait drops the response
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc0000c;
    mem_addr_ok = 1'b1;
    tick();
    quiet();
    flush = 1'b1;
    settle();
    chk("fi_flush_dok", 32'(inst_data_ok), 32'd0);
    tick();
    flush       = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    chk("fi_cancel_dok", 32'(inst_data_ok), 32'd0);
    tick();
    quiet();
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc00010;
    mem_addr_ok = 1'b1;
    settle();
    chk("fi_next_aok", 32'(inst_addr_ok), 32'd1);
    tick();
    quiet();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h33333333;
    settle();
    chk("fi_next_dok", 32'(inst_data_ok), 32'd1);
    tick();
    quiet();

    // flush together with the inst address accept
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc00014;
    mem_addr_ok = 1'b1;
    flush       = 1'b1;
    settle();
    chk("fa_aok", 32'(inst_addr_ok), 32'd1);
    tick();
    quiet();
    mem_data_ok = 1'b1;
    settle();
    chk("fa_dok", 32'(inst_data_ok), 32'd0);
    tick();
    quiet();

    // flush together with the inst data_ok
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc00018;
    mem_addr_ok = 1'b1;
    tick();
    quiet();
    mem_data_ok = 1'b1;
    flush       = 1'b1;
    settle();
    chk("fs_dok", 32'(inst_data_ok), 32'd0);
    tick();
    quiet();

    // reset mid-transaction, then a stray data_ok
    inst_req    = 1'b1;
    inst_addr   = 32'hbfc0001c;
    mem_addr_ok = 1'b1;
    tick();
    quiet();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mem_data_ok = 1'b1;
    settle();
    chk("r_stray_idok", 32'(inst_data_ok), 32'd0);
    chk("r_stray_ddok", 32'(data_data_ok), 32'd0);
    chk("r_stray_req", 32'(mem_req), 32'd0);
    tick();
    quiet();
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd1;
    data_addr   = 32'h00003002;
    mem_addr_ok = 1'b1;
    settle();
    chk("r_d_aok", 32'(data_addr_ok), 32'd1);
    chk("r_d_size", 32'(mem_size), 32'd1);
    tick();
    quiet();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000abcd;
    settle();
    chk("r_d_dok", 32'(data_data_ok), 32'd1);
    chk("r_d_rdata", data_rdata, 32'h0000abcd);
    tick();
    quiet();
    settle();
    chk("end_idle_req", 32'(mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
